// File: rtl/control_mc_pkg.sv
// Shared select encodings, FSM states and opcode constants for the multi-cycle
// RV32I/RV32M control path.
package control_mc_pkg;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} ImmSel_e;
    typedef enum logic {B_REG, B_IMM} BSel_e;
    typedef enum logic {A_REG, A_PC} ASel_e;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_BSEL
    } ALUSel_e;

    localparam int WBSEL_W = 2;
    typedef enum logic [WBSEL_W-1:0] {WB_MEM, WB_ALU, WB_PC4, WB_MDU} WBSel_e;
    typedef enum logic {PC_4, PC_ALU} PCSel_e;

    typedef enum logic [1:0] {S_IDLE, S_LSU, S_MDU} CtrlState_e;
    typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} MduOp_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Datapath select bundle produced by the decoder. reg_wen and st_mem are
    // "instruction wants to" flags; the FSM decides when they reach the pins.
    typedef struct packed {
        ImmSel_e imm_sel;
        logic    reg_wen;
        logic    br_un;
        BSel_e   b_sel;
        ASel_e   a_sel;
        ALUSel_e alu_sel;
        logic    st_mem;
        WBSel_e  wb_sel;
    } CtrlSel_s;

    // funct3 to ALU op; alt selects SUB/SRA (inst[30]).
    function automatic ALUSel_e alu_of_f3(input logic [2:0] f3, input logic alt);
        ALUSel_e op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_mc_dec.sv
// Pure combinational RV32I decoder with RV32M gated by EN_M.
module control_dec
    import control_mc_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0] i_inst,
    output CtrlSel_s    o_sel,
    output logic        o_is_br,
    output logic        o_is_jp,
    output logic        o_is_mem,
    output logic        o_is_mdu,
    output logic        o_legal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_fields;

    assign opc = i_inst[6:0];
    assign f3  = i_inst[14:12];
    assign f7  = i_inst[31:25];
    assign unused_fields = ^{i_inst[24:15], i_inst[11:7]};

    // Opcode table; illegal encodings clear every write/request flag.
    always_comb begin
        CtrlSel_s sel;
        logic     legal, is_br, is_jp, is_mem, is_mdu;
        sel    = '{imm_sel: IMM_I, reg_wen: 1'b0, br_un: 1'b0, b_sel: B_REG,
                   a_sel: A_REG, alu_sel: ALU_ADD, st_mem: 1'b0, wb_sel: WB_ALU};
        legal  = 1'b0;
        is_br  = 1'b0;
        is_jp  = 1'b0;
        is_mem = 1'b0;
        is_mdu = 1'b0;
        case (opc)
            OPC_LUI: begin
                legal = 1'b1;
                sel.imm_sel = IMM_U; sel.reg_wen = 1'b1;
                sel.b_sel = B_IMM;   sel.alu_sel = ALU_BSEL;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                sel.imm_sel = IMM_U; sel.reg_wen = 1'b1;
                sel.a_sel = A_PC;    sel.b_sel = B_IMM;
            end
            OPC_JAL: begin
                legal = 1'b1; is_jp = 1'b1;
                sel.imm_sel = IMM_J; sel.reg_wen = 1'b1; sel.a_sel = A_PC;
                sel.b_sel = B_IMM;   sel.wb_sel = WB_PC4;
            end
            OPC_JALR: begin
                legal = (f3 == 3'd0); is_jp = 1'b1;
                sel.imm_sel = IMM_I; sel.reg_wen = 1'b1;
                sel.b_sel = B_IMM;   sel.wb_sel = WB_PC4;
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'd2) && (f3 != 3'd3); is_br = 1'b1;
                sel.imm_sel = IMM_B; sel.a_sel = A_PC; sel.b_sel = B_IMM;
                sel.br_un = f3[1];
            end
            OPC_LOAD: begin
                legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                        (f3 == 3'd4) || (f3 == 3'd5);
                is_mem = 1'b1;
                sel.imm_sel = IMM_I; sel.b_sel = B_IMM;
                sel.reg_wen = 1'b1;  sel.wb_sel = WB_MEM;
            end
            OPC_STORE: begin
                legal = !f3[2] && (f3[1:0] != 2'd3); is_mem = 1'b1;
                sel.imm_sel = IMM_S; sel.b_sel = B_IMM; sel.st_mem = 1'b1;
            end
            OPC_OPIMM: begin
                sel.imm_sel = IMM_I; sel.b_sel = B_IMM; sel.reg_wen = 1'b1;
                if (f3 == 3'd1) begin
                    legal = (f7 == 7'h00);
                    sel.alu_sel = ALU_SLL;
                end else if (f3 == 3'd5) begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                    sel.alu_sel = alu_of_f3(f3, i_inst[30]);
                end else begin
                    legal = 1'b1;
                    sel.alu_sel = alu_of_f3(f3, 1'b0);
                end
            end
            OPC_OP: begin
                sel.reg_wen = 1'b1;
                if (f7 == 7'h00) begin
                    legal = 1'b1;
                    sel.alu_sel = alu_of_f3(f3, 1'b0);
                end else if (f7 == 7'h20) begin
                    legal = (f3 == 3'd0) || (f3 == 3'd5);
                    sel.alu_sel = alu_of_f3(f3, 1'b1);
                end else if ((f7 == 7'h01) && EN_M) begin
                    legal = 1'b1; is_mdu = 1'b1;
                    sel.wb_sel = WB_MDU;
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            sel.reg_wen = 1'b0;
            sel.st_mem  = 1'b0;
            is_br = 1'b0; is_jp = 1'b0; is_mem = 1'b0; is_mdu = 1'b0;
        end
        o_sel    = sel;
        o_legal  = legal;
        o_is_br  = is_br;
        o_is_jp  = is_jp;
        o_is_mem = is_mem;
        o_is_mdu = is_mdu;
    end

endmodule

// File: rtl/control_mc.sv
// Multi-cycle control: wraps the decoder with an FSM that holds each
// instruction until the LSU handshake or fixed-latency MDU lets it retire.
//
// state  | meaning
// S_IDLE | decode i_inst; single-cycle ops, illegal and zero-wait LSU retire here
// S_LSU  | lsu_VALID held, waiting for lsu_READY or timeout abort
// S_MDU  | counting MDU latency, retire with WB_MDU when counter hits MDU_LAT
module control_mc
    import control_mc_pkg::*;
#(
    parameter bit EN_M        = 1'b1,
    parameter int MDU_LAT     = 4,
    parameter int LSU_TIMEOUT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_inst,
    input  logic        i_inst_vld,
    input  logic        i_br_eq,
    input  logic        i_br_lt,
    output ImmSel_e     o_imm_sel,
    output logic        o_reg_wen,
    output logic        o_br_un,
    output BSel_e       o_b_sel,
    output ASel_e       o_a_sel,
    output ALUSel_e     o_alu_sel,
    output logic        o_st_mem,
    output WBSel_e      o_wb_sel,
    output PCSel_e      o_pc_sel,
    output logic        o_pc_en,
    output logic        o_inst_vld,
    output logic        o_illegal,
    output logic        o_mdu_start,
    output logic [2:0]  o_mdu_op,
    output logic        o_busy,
    output logic        o_lsu_err,
    output logic        lsu_VALID,
    input  logic        lsu_READY
);

    localparam int CNT_MAX = (MDU_LAT > LSU_TIMEOUT) ? MDU_LAT : LSU_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MDU_TC  = CNT_W'(MDU_LAT);
    localparam logic [CNT_W-1:0] LSU_TC  = CNT_W'(LSU_TIMEOUT);

    CtrlSel_s   sel;
    logic       is_br, is_jp, is_mem, is_mdu, legal;
    CtrlState_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       retire, lsu_vld, lsu_err, illegal, mdu_start, br_taken;

    control_dec #(.EN_M(EN_M)) u_dec (
        .i_inst   (i_inst),
        .o_sel    (sel),
        .o_is_br  (is_br),
        .o_is_jp  (is_jp),
        .o_is_mem (is_mem),
        .o_is_mdu (is_mdu),
        .o_legal  (legal)
    );

    // State and shared wait/latency counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, handshake and retire strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retire    = 1'b0;
        lsu_vld   = 1'b0;
        lsu_err   = 1'b0;
        illegal   = 1'b0;
        mdu_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_inst_vld) begin
                    if (!legal) begin
                        illegal = 1'b1;
                        retire  = 1'b1;
                    end else if (is_mem) begin
                        lsu_vld = 1'b1;
                        if (lsu_READY) begin
                            retire = 1'b1;
                        end else begin
                            state_d = S_LSU;
                            cnt_d   = CNT_ONE;
                        end
                    end else if (is_mdu) begin
                        mdu_start = 1'b1;
                        state_d   = S_MDU;
                        cnt_d     = CNT_ONE;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            S_LSU: begin
                // READY is checked first so it wins over a coincident timeout.
                if (lsu_READY) begin
                    lsu_vld = 1'b1;
                    retire  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if ((LSU_TIMEOUT > 0) && (cnt_q == LSU_TC)) begin
                    lsu_err = 1'b1;
                    retire  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    lsu_vld = 1'b1;
                    if (LSU_TIMEOUT > 0) cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_MDU: begin
                if (cnt_q == MDU_TC) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Branch resolution: inst[14] picks lt vs eq, inst[12] inverts the sense.
    always_comb begin
        br_taken = i_inst[12] ^ (i_inst[14] ? i_br_lt : i_br_eq);
        o_pc_sel = PC_4;
        if (retire && !lsu_err && !illegal) begin
            if (is_jp)                  o_pc_sel = PC_ALU;
            else if (is_br && br_taken) o_pc_sel = PC_ALU;
        end
    end

    assign o_imm_sel   = sel.imm_sel;
    assign o_br_un     = sel.br_un;
    assign o_b_sel     = sel.b_sel;
    assign o_a_sel     = sel.a_sel;
    assign o_alu_sel   = sel.alu_sel;
    assign o_wb_sel    = sel.wb_sel;
    assign o_reg_wen   = retire && sel.reg_wen && !lsu_err;
    assign o_st_mem    = lsu_vld && sel.st_mem;
    assign o_pc_en     = retire;
    assign o_inst_vld  = legal && (i_inst_vld || (state_q != S_IDLE));
    assign o_illegal   = illegal;
    assign o_mdu_start = mdu_start;
    assign o_mdu_op    = i_inst[14:12];
    assign o_busy      = (state_q != S_IDLE);
    assign o_lsu_err   = lsu_err;
    assign lsu_VALID   = lsu_vld;

endmodule

// File: tb/tb_control_mc.sv
// Randomized scoreboard bench for control_mc plus a directed check of a
// second instance built with EN_M=0 and no LSU timeout.
module tb_control_mc;
    import control_mc_pkg::*;

    localparam int A_MLAT = 4;
    localparam int A_TO   = 8;

    logic i_clk, i_rst_n;
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [31:0] i_inst;
    logic i_inst_vld, i_br_eq, i_br_lt, lsu_READY;
    ImmSel_e o_imm_sel; BSel_e o_b_sel; ASel_e o_a_sel; ALUSel_e o_alu_sel;
    WBSel_e o_wb_sel; PCSel_e o_pc_sel; logic [2:0] o_mdu_op;
    logic o_reg_wen, o_br_un, o_st_mem, o_pc_en, o_inst_vld, o_illegal;
    logic o_mdu_start, o_busy, o_lsu_err, lsu_VALID;

    logic [31:0] b_inst;
    logic b_inst_vld, b_br_eq, b_br_lt, b_ready;
    ImmSel_e b_imm_sel; BSel_e b_b_sel; ASel_e b_a_sel; ALUSel_e b_alu_sel;
    WBSel_e b_wb_sel; PCSel_e b_pc_sel; logic [2:0] b_mdu_op;
    logic b_reg_wen, b_br_un, b_st_mem, b_pc_en, b_inst_vld_o, b_illegal;
    logic b_mdu_start, b_busy, b_lsu_err, b_valid;

    control_mc #(.EN_M(1'b1), .MDU_LAT(A_MLAT), .LSU_TIMEOUT(A_TO)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inst(i_inst), .i_inst_vld(i_inst_vld),
        .i_br_eq(i_br_eq), .i_br_lt(i_br_lt), .o_imm_sel(o_imm_sel),
        .o_reg_wen(o_reg_wen), .o_br_un(o_br_un), .o_b_sel(o_b_sel),
        .o_a_sel(o_a_sel), .o_alu_sel(o_alu_sel), .o_st_mem(o_st_mem),
        .o_wb_sel(o_wb_sel), .o_pc_sel(o_pc_sel), .o_pc_en(o_pc_en),
        .o_inst_vld(o_inst_vld), .o_illegal(o_illegal), .o_mdu_start(o_mdu_start),
        .o_mdu_op(o_mdu_op), .o_busy(o_busy), .o_lsu_err(o_lsu_err),
        .lsu_VALID(lsu_VALID), .lsu_READY(lsu_READY));

    control_mc #(.EN_M(1'b0), .MDU_LAT(3), .LSU_TIMEOUT(0)) u_dut_nom (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inst(b_inst), .i_inst_vld(b_inst_vld),
        .i_br_eq(b_br_eq), .i_br_lt(b_br_lt), .o_imm_sel(b_imm_sel),
        .o_reg_wen(b_reg_wen), .o_br_un(b_br_un), .o_b_sel(b_b_sel),
        .o_a_sel(b_a_sel), .o_alu_sel(b_alu_sel), .o_st_mem(b_st_mem),
        .o_wb_sel(b_wb_sel), .o_pc_sel(b_pc_sel), .o_pc_en(b_pc_en),
        .o_inst_vld(b_inst_vld_o), .o_illegal(b_illegal), .o_mdu_start(b_mdu_start),
        .o_mdu_op(b_mdu_op), .o_busy(b_busy), .o_lsu_err(b_lsu_err),
        .lsu_VALID(b_valid), .lsu_READY(b_ready));

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Expected per-instruction outcome, observed at its retire strobe.
    typedef struct {
        int lat; int bub; bit legal; bit wen; WBSel_e wb; PCSel_e pc;
        int vcnt; int scnt; int mcnt; int mop; int icnt; int ecnt;
        bit chk_un; bit un; bit chk_alu; ALUSel_e alu; bit busy;
    } exp_t;
    exp_t sb[$];

    function automatic bit isa_legal(logic [31:0] x, bit en_m);
        logic [2:0] f3 = x[14:12];
        logic [6:0] f7 = x[31:25];
        case (x[6:0])
            7'b0110111, 7'b0010111, 7'b1101111: return 1'b1;
            7'b1100111: return f3 == 3'd0;
            7'b1100011: return (f3 != 3'd2) && (f3 != 3'd3);
            7'b0000011: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            7'b0100011: return f3 inside {3'd0, 3'd1, 3'd2};
            7'b0010011: begin
                if (f3 == 3'd1) return f7 == 7'h00;
                if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
                return 1'b1;
            end
            7'b0110011: return (f7 == 7'h00) ||
                               ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))) ||
                               ((f7 == 7'h01) && en_m);
            default: return 1'b0;
        endcase
    endfunction

    function automatic ALUSel_e alu_expect(logic [31:0] x);
        bit is_op = (x[6:0] == 7'b0110011);
        case (x[14:12])
            3'd0: return (is_op && x[30]) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return x[30] ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // d = cycles lsu_READY stays low after the instruction is presented.
    function automatic exp_t model(logic [31:0] x, int d, bit eq, bit lt, int bub,
                                   bit en_m, int mlat, int to);
        exp_t e;
        logic [6:0] opc = x[6:0];
        logic [2:0] f3  = x[14:12];
        bit ld  = (opc == 7'b0000011);
        bit st  = (opc == 7'b0100011);
        bit br  = (opc == 7'b1100011);
        bit jp  = (opc == 7'b1101111) || (opc == 7'b1100111);
        bit mdu = (opc == 7'b0110011) && (x[31:25] == 7'h01);
        e.lat = 0; e.bub = bub; e.legal = isa_legal(x, en_m); e.wen = 0;
        e.wb = WB_ALU; e.pc = PC_4; e.vcnt = 0; e.scnt = 0; e.mcnt = 0;
        e.mop = 0; e.icnt = 0; e.ecnt = 0; e.chk_un = 0; e.un = 0;
        e.chk_alu = 0; e.alu = ALU_ADD; e.busy = 0;
        if (!e.legal) begin
            e.icnt = 1;
            return e;
        end
        if (ld || st) begin
            if (to > 0 && d > to) begin
                e.lat = to; e.ecnt = 1; e.vcnt = to;
            end else begin
                e.lat = d; e.vcnt = d + 1;
            end
            if (st) e.scnt = e.vcnt;
            e.wen = ld && (e.ecnt == 0);
            if (ld) e.wb = WB_MEM;
        end else if (mdu) begin
            e.lat = mlat; e.mcnt = 1; e.mop = int'(f3); e.wen = 1; e.wb = WB_MDU;
        end else if (br) begin
            e.chk_un = 1; e.un = f3[1];
            if (f3[0] ^ (f3[2] ? lt : eq)) e.pc = PC_ALU;
        end else if (jp) begin
            e.pc = PC_ALU; e.wen = 1; e.wb = WB_PC4;
        end else begin
            e.wen = 1;
            if (opc == 7'b0110011 || opc == 7'b0010011) begin
                e.chk_alu = 1; e.alu = alu_expect(x);
            end
        end
        e.busy = (e.lat > 0);
        return e;
    endfunction

    function automatic logic [31:0] gen_inst(int cls);
        logic [31:0] x = $urandom;
        logic [2:0]  f3 = 3'($urandom_range(0, 7));
        case (cls)
            0: begin
                x[6:0] = 7'b0110011; x[14:12] = f3;
                x[31:25] = ($urandom_range(0, 1) == 1 && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
            end
            1: begin
                x[6:0] = 7'b0010011; x[14:12] = f3;
                if (f3 == 3'd1) x[31:25] = 7'h00;
                if (f3 == 3'd5) x[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            2: begin
                x[6:0] = 7'b0000011;
                case ($urandom_range(0, 4))
                    0: x[14:12] = 3'd0; 1: x[14:12] = 3'd1; 2: x[14:12] = 3'd2;
                    3: x[14:12] = 3'd4; default: x[14:12] = 3'd5;
                endcase
            end
            3: begin x[6:0] = 7'b0100011; x[14:12] = 3'($urandom_range(0, 2)); end
            4: begin
                x[6:0] = 7'b1100011;
                x[14:12] = (f3 == 3'd2 || f3 == 3'd3) ? 3'd0 : f3;
            end
            5: x[6:0] = 7'b1101111;
            6: begin x[6:0] = 7'b1100111; x[14:12] = 3'd0; end
            7: x[6:0] = ($urandom_range(0, 1) == 1) ? 7'b0110111 : 7'b0010111;
            8: begin x[6:0] = 7'b0110011; x[31:25] = 7'h01; end
            9: x[6:0] = 7'b0110011;
            default: ;
        endcase
        return x;
    endfunction

    // Presents one instruction (after bub bubbles) for as long as the model
    // says it takes to retire, driving lsu_READY low for its first d cycles.
    task automatic issue(input logic [31:0] x, input int d, input bit eq,
                         input bit lt, input int bub);
        exp_t e = model(x, d, eq, lt, bub, 1'b1, A_MLAT, A_TO);
        sb.push_back(e);
        repeat (bub) begin
            i_inst_vld = 1'b0; i_inst = $urandom; lsu_READY = 1'($urandom);
            @(posedge i_clk); #1;
        end
        for (int k = 0; k <= e.lat; k++) begin
            i_inst = x; i_inst_vld = 1'b1; i_br_eq = eq; i_br_lt = lt;
            lsu_READY = (x[6:0] == 7'b0000011 || x[6:0] == 7'b0100011) ?
                        (k >= d) : 1'($urandom);
            @(posedge i_clk); #1;
        end
        i_inst_vld = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge i_clk);
        chk("scoreboard_drain", sb.size(), 0);
    endtask

    // Monitor: accumulate strobes per instruction, compare at each retire.
    bit mon_en = 1'b0;
    int m_cyc, m_v, m_s, m_m, m_op, m_i, m_e;
    exp_t m_x;
    always @(negedge i_clk) begin
        if (!mon_en) begin
            m_cyc = 0; m_v = 0; m_s = 0; m_m = 0; m_op = 0; m_i = 0; m_e = 0;
        end else begin
            m_cyc++;
            if (lsu_VALID) m_v++;
            if (o_st_mem) m_s++;
            if (o_mdu_start) begin m_m++; m_op = int'(o_mdu_op); end
            if (o_illegal) m_i++;
            if (o_lsu_err) m_e++;
            chk("reg_wen_off_retire", int'(o_reg_wen && !o_pc_en), 0);
            chk("st_mem_without_valid", int'(o_st_mem && !lsu_VALID), 0);
            if (o_pc_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    m_x = sb.pop_front();
                    chk("retire_cycle", m_cyc - 1, m_x.lat + m_x.bub);
                    chk("reg_wen", int'(o_reg_wen), int'(m_x.wen));
                    if (m_x.wen) chk("wb_sel", int'(o_wb_sel), int'(m_x.wb));
                    chk("pc_sel", int'(o_pc_sel), int'(m_x.pc));
                    chk("inst_vld", int'(o_inst_vld), int'(m_x.legal));
                    chk("busy_at_retire", int'(o_busy), int'(m_x.busy));
                    chk("lsu_valid_cycles", m_v, m_x.vcnt);
                    chk("st_mem_cycles", m_s, m_x.scnt);
                    chk("mdu_start_pulses", m_m, m_x.mcnt);
                    if (m_x.mcnt != 0) chk("mdu_op", m_op, m_x.mop);
                    chk("illegal_pulses", m_i, m_x.icnt);
                    chk("lsu_err_pulses", m_e, m_x.ecnt);
                    if (m_x.chk_un) chk("br_un", int'(o_br_un), int'(m_x.un));
                    if (m_x.chk_alu) chk("alu_sel", int'(o_alu_sel), int'(m_x.alu));
                end
                m_cyc = 0; m_v = 0; m_s = 0; m_m = 0; m_i = 0; m_e = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, sb=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_inst = '0; i_inst_vld = 1'b0; i_br_eq = 1'b0;
        i_br_lt = 1'b0; lsu_READY = 1'b0;
        b_inst = '0; b_inst_vld = 1'b0; b_br_eq = 1'b0; b_br_lt = 1'b0; b_ready = 1'b0;
        i_inst = 32'h0000006F;
        @(negedge i_clk);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_pc_en", int'(o_pc_en), 0);
        chk("rst_lsu_valid", int'(lsu_VALID), 0);
        chk("rst_pc_sel", int'(o_pc_sel), int'(PC_4));
        chk("rst_strobes", int'({o_reg_wen, o_st_mem, o_mdu_start, o_illegal, o_lsu_err}), 0);
        #7 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        mon_en = 1'b1;

        issue(32'h003100B3, 0, 0, 0, 0);   // add
        issue(32'h00032283, 3, 0, 0, 0);   // lw, 3 wait cycles
        issue(32'h023100B3, 0, 0, 0, 0);   // mul
        issue(32'h00112023, 100, 0, 0, 0); // sw, READY never comes -> timeout
        issue(32'h00112023, A_TO, 0, 0, 0); // sw, READY exactly at timeout
        issue(32'h00000463, 0, 1, 0, 0);   // beq taken
        issue(32'h00000463, 0, 0, 1, 1);   // beq not taken, after a bubble
        issue(32'h0000E463, 0, 0, 1, 0);   // bltu taken
        issue(32'h0080006F, 0, 0, 0, 0);   // jal
        issue(32'h00032283, 0, 0, 0, 0);   // lw zero-wait

        for (int n = 0; n < 300; n++) begin
            int cls = $urandom_range(0, 11);
            int bub = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            issue(gen_inst(cls), $urandom_range(0, 11), 1'($urandom), 1'($urandom), bub);
        end
        drain();

        // Reset while stalled in S_LSU.
        mon_en = 1'b0;
        i_inst = 32'h00032283; i_inst_vld = 1'b1; lsu_READY = 1'b0;
        repeat (3) begin @(posedge i_clk); #1; end
        chk("pre_rst_busy", int'(o_busy), 1);
        #2 i_rst_n = 1'b0; i_inst_vld = 1'b0;
        #1;
        chk("rst_mid_lsu_valid", int'(lsu_VALID), 0);
        chk("rst_mid_busy", int'(o_busy), 0);
        chk("rst_mid_pc_en", int'(o_pc_en), 0);
        chk("rst_mid_reg_wen", int'(o_reg_wen), 0);
        repeat (2) begin
            @(negedge i_clk);
            chk("rst_hold_pc_en", int'(o_pc_en), 0);
            chk("rst_hold_valid", int'(lsu_VALID), 0);
        end
        #2 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        mon_en = 1'b1;
        issue(32'hFFFFFFFF, 0, 0, 0, 0);
        drain();

        // EN_M=0, no timeout instance.
        @(posedge i_clk); #1;
        b_inst = 32'h023100B3; b_inst_vld = 1'b1;
        @(negedge i_clk);
        chk("nom_mul_illegal", int'(b_illegal), 1);
        chk("nom_mul_pc_en", int'(b_pc_en), 1);
        chk("nom_mul_reg_wen", int'(b_reg_wen), 0);
        chk("nom_mul_mdu_start", int'(b_mdu_start), 0);
        chk("nom_mul_inst_vld", int'(b_inst_vld_o), 0);
        @(posedge i_clk); #1;
        b_inst = 32'h00032283; b_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            chk("nom_lw_wait_valid", int'(b_valid), 1);
            chk("nom_lw_wait_pc_en", int'(b_pc_en), 0);
            chk("nom_lw_wait_err", int'(b_lsu_err), 0);
            @(posedge i_clk); #1;
        end
        b_ready = 1'b1;
        @(negedge i_clk);
        chk("nom_lw_retire", int'(b_pc_en), 1);
        chk("nom_lw_reg_wen", int'(b_reg_wen), 1);
        chk("nom_lw_wb_sel", int'(b_wb_sel), int'(WB_MEM));
        @(posedge i_clk); #1;
        b_inst_vld = 1'b0; b_ready = 1'b0;
        @(negedge i_clk);
        chk("nom_idle_busy", int'(b_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/control_mc.md
Name: control_mc

Overview:
Multi-cycle successor to the single-cycle RV32I control decoder. It decodes RV32I, plus RV32M when enabled, and drives the same datapath selects. A small FSM holds each instruction until it can retire:
- a true valid/ready LSU handshake with optional timeout;
- fixed-latency MDU sequencing.
o_pc_en is the single retire/advance strobe to the fetch stage.

Parameters:
EN_M, 1, 1 = decode RV32M (opcode 0110011, funct7 0000001); 0 = those encodings are illegal.
MDU_LAT, 4, MDU result latency in cycles after o_mdu_start (>=1).
LSU_TIMEOUT, 0, max wait cycles for lsu_READY; 0 = wait forever.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_inst  in  32  instruction; must stay stable while o_pc_en=0
i_inst_vld  in  1  fetch has a valid instruction
i_br_eq  in  1  branch comparator equal
i_br_lt  in  1  branch comparator less-than (signedness per o_br_un)
o_imm_sel  out  ImmSel_e  immediate format
o_reg_wen  out  1  register write; asserted only on retire cycle
o_br_un  out  1  unsigned compare
o_b_sel  out  BSel_e  ALU B mux
o_a_sel  out  ASel_e  ALU A mux
o_alu_sel  out  ALUSel_e  ALU op
o_st_mem  out  1  store request; high only while lsu_VALID high
o_wb_sel  out  WBSel_e  writeback mux (adds WB_MDU)
o_pc_sel  out  PCSel_e  next-PC select, valid on retire cycle
o_pc_en  out  1  retire / PC advance strobe
o_inst_vld  out  1  current instruction is legal
o_illegal  out  1  one-cycle pulse on an illegal instruction
o_mdu_start  out  1  one-cycle MDU start pulse
o_mdu_op  out  3  MDU funct3 (mul..remu)
o_busy  out  1  FSM not in S_IDLE
o_lsu_err  out  1  one-cycle pulse on LSU timeout abort
lsu_VALID  out  1  LSU request
lsu_READY  in  1  LSU accepts / completes

Behaviour:
- Reset (async): state=S_IDLE, counters=0. All strobes are 0: o_pc_en, o_reg_wen, lsu_VALID, o_st_mem, o_mdu_start, o_illegal, o_lsu_err, o_busy. o_pc_sel=PC_4.
- Decode is combinational from i_inst and matches the RV32I table. Sticky registered state is limited to FSM state plus one counter of width $clog2(max(MDU_LAT,LSU_TIMEOUT)+1).
- S_IDLE, i_inst_vld=0: bubble. o_pc_en=0 and all write/request strobes are 0.
- S_IDLE, legal ALU/branch/jump/LUI/AUIPC: retire in the same cycle. o_pc_en=1 and o_reg_wen is as decoded.
- o_pc_sel on branches: lt-type if inst[14], else eq-type. Select PC_ALU when inst[12]^cmp is true, else PC_4.
- o_pc_sel on jumps: PC_ALU.
- S_IDLE, load/store: lsu_VALID=1 in the same cycle.
  - lsu_READY=1 that cycle: retire (zero-wait).
  - Otherwise go to S_LSU with counter=1.
- S_LSU: hold lsu_VALID=1 and keep decode outputs stable.
  - On lsu_READY=1: retire; next state S_IDLE.
  - If LSU_TIMEOUT>0 and counter==LSU_TIMEOUT without READY: abort that cycle. Effects: lsu_VALID=0, o_lsu_err=1, o_pc_en=1, o_reg_wen=0, o_pc_sel=PC_4. Next state S_IDLE.
  - READY and timeout in the same cycle: READY wins (normal retire, no error).
- S_IDLE, MUL/DIV (EN_M=1): o_mdu_start=1 and o_mdu_op=inst[14:12]. Go to S_MDU with counter=1.
- S_MDU: increment counter. When counter==MDU_LAT: retire with o_wb_sel=WB_MDU, o_reg_wen=1, PC_4. The instruction occupies MDU_LAT+1 cycles in total.
- Illegal in S_IDLE with i_inst_vld=1: o_inst_vld=0, o_illegal=1, o_pc_en=1, PC_4, no writes or requests.
- o_reg_wen is never high on a non-retire cycle. lsu_VALID never drops before READY except on timeout abort.
- Async reset in S_LSU/S_MDU: lsu_VALID drops immediately, no retire, state returns to S_IDLE.
- Back-to-back: the next instruction may decode in the cycle after retire. No forced idle cycle.

Decomposition:
- Extend singlecycle_pkg with:
  - WB_MDU in WBSel_e (adjust WBSEL_W);
  - a CtrlState_e enum {S_IDLE,S_LSU,S_MDU};
  - an MduOp_e enum (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU).
- One sub-module, control_dec: the pure combinational decoder (RV32I table plus gated RV32M). It outputs the select bundle, is_br, is_jp, is_mem, is_mdu and legal.
- control_mc wraps control_dec with the FSM, counter, handshake and pc_sel logic.

Test Plan:
- add x1,x2,x3 (0x003100B3), i_inst_vld=1 -> same-cycle o_pc_en=1, o_reg_wen=1, o_alu_sel=ALU_ADD, o_pc_sel=PC_4, o_busy=0.
- lw x5,0(x6) (0x00032283), lsu_READY low for 3 cycles then high -> lsu_VALID high for 4 cycles. o_pc_en=0 for 3 cycles, then o_pc_en=1 with o_reg_wen=1 and o_wb_sel=WB_MEM on cycle 4.
- mul x1,x2,x3 (0x023100B3), EN_M=1, MDU_LAT=4 -> o_mdu_start pulse in cycle 0 with o_mdu_op=0. Retire in cycle 4 with WB_MDU. With EN_M=0 -> o_illegal=1, o_pc_en=1, o_reg_wen=0.
- sw x1,0(x2) (0x00112023), LSU_TIMEOUT=8, READY held low -> o_st_mem/lsu_VALID high for 8 cycles. Cycle 8: o_lsu_err=1, o_pc_en=1, lsu_VALID=0. READY rising exactly in cycle 8 -> normal retire, no error.
- beq x0,x0,+8 (0x00000463): i_br_eq=1 -> PC_ALU; i_br_eq=0 -> PC_4. bltu (0x0000E463) with i_br_lt=1 -> o_br_un=1, PC_ALU.
- lw stalled in S_LSU, then i_rst_n low mid-wait -> lsu_VALID=0 immediately, state S_IDLE, no o_pc_en or o_reg_wen. After release, 0xFFFFFFFF -> o_illegal pulse, o_pc_en=1.
